// File: rtl/risc_pkg.sv
// Shared constants for the RISC control unit: opcodes, FSM states, bus mux selects.
package risc_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1,
    S_RD1, S_RD2, S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
  } state_e;

  localparam logic [2:0] SEL1_R0 = 3'd0;
  localparam logic [2:0] SEL1_R1 = 3'd1;
  localparam logic [2:0] SEL1_R2 = 3'd2;
  localparam logic [2:0] SEL1_R3 = 3'd3;
  localparam logic [2:0] SEL1_PC = 3'd4;

  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  function automatic logic [2:0] reg_sel1(input logic [1:0] r);
    logic [2:0] s;
    case (r)
      2'd0:    s = SEL1_R0;
      2'd1:    s = SEL1_R1;
      2'd2:    s = SEL1_R2;
      default: s = SEL1_R3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/risc_cu_decode.sv
// Instruction field split, opcode legality and one-hot destination register load map.
module risc_cu_decode
  import risc_pkg::*;
#(
  parameter int DATAWIDTH   = 8,
  parameter int opcode_size = 4
) (
  input  logic [DATAWIDTH-1:0]   instruction,
  output logic [opcode_size-1:0] opcode,
  output logic [1:0]             src,
  output logic [1:0]             dest,
  output logic                   legal,
  output logic [3:0]             ld_r_dest
);

  always_comb begin
    opcode    = instruction[DATAWIDTH-1 -: opcode_size];
    src       = instruction[3:2];
    dest      = instruction[1:0];
    legal     = (4'(opcode) <= OP_BRZ);
    ld_r_dest = 4'b0001 << dest;
  end

endmodule

// File: rtl/risc_control_unit.sv
// Micro-sequencer for the 8-bit RISC datapath: fetch, decode and execute one instruction.
// Optional: define RISC_CU_ILLEGAL_TRAP_EN to halt on illegal opcodes (default: run as NOP).
module risc_control_unit
  import risc_pkg::*;
#(
  parameter int DATAWIDTH   = 8,
  parameter int opcode_size = 4,
  parameter int sel1_size   = 3,
  parameter int sel2_size   = 2
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [DATAWIDTH-1:0] instruction,
  input  logic                 zero_flag,
  output logic                 ld_r0,
  output logic                 ld_r1,
  output logic                 ld_r2,
  output logic                 ld_r3,
  output logic                 ld_pc,
  output logic                 inc_pc,
  output logic                 ld_ir,
  output logic                 ld_address_reg,
  output logic                 ld_reg_y,
  output logic                 ld_reg_z,
  output logic [sel1_size-1:0] sel_bus1_mux,
  output logic [sel2_size-1:0] sel_bus2_mux,
  output logic                 mem_write,
  output logic                 instr_done,
  output logic                 halted
);

  state_e state_q, state_d;

  logic [opcode_size-1:0] opcode;
  logic [1:0]             src, dest;
  logic                   legal;
  logic [3:0]             ld_r_dest;
  logic [3:0]             ld_r;
  logic [2:0]             sel1;
  logic [1:0]             sel2;

  risc_cu_decode #(
    .DATAWIDTH  (DATAWIDTH),
    .opcode_size(opcode_size)
  ) u_decode (
    .instruction(instruction),
    .opcode     (opcode),
    .src        (src),
    .dest       (dest),
    .legal      (legal),
    .ld_r_dest  (ld_r_dest)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    ld_r           = '0;
    ld_pc          = 1'b0;
    inc_pc         = 1'b0;
    ld_ir          = 1'b0;
    ld_address_reg = 1'b0;
    ld_reg_y       = 1'b0;
    ld_reg_z       = 1'b0;
    sel1           = '0;
    sel2           = '0;
    mem_write      = 1'b0;
    instr_done     = 1'b0;
    halted         = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FET1;
      S_FET1: begin
        sel1 = SEL1_PC; sel2 = SEL2_BUS1;
        ld_address_reg = 1'b1; inc_pc = 1'b1;
        state_d = S_FET2;
      end
      S_FET2: begin
        sel2 = SEL2_MEM; ld_ir = 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (!legal) begin
`ifdef RISC_CU_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          instr_done = 1'b1;
          state_d    = S_FET1;
`endif
        end else begin
          case (opcode)
            OP_NOP: begin
              instr_done = 1'b1; state_d = S_FET1;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              sel1 = reg_sel1(src); sel2 = SEL2_BUS1; ld_reg_y = 1'b1;
              state_d = S_EX1;
            end
            OP_NOT: begin
              sel1 = reg_sel1(src); sel2 = SEL2_ALU;
              ld_reg_z = 1'b1; ld_r = ld_r_dest; instr_done = 1'b1;
              state_d = S_FET1;
            end
            OP_RD, OP_WR, OP_BR: begin
              sel1 = SEL1_PC; sel2 = SEL2_BUS1; ld_address_reg = 1'b1;
              state_d = (opcode == OP_RD) ? S_RD1 :
                        (opcode == OP_WR) ? S_WR1 : S_BR1;
            end
            OP_BRZ: begin
              if (zero_flag) begin
                sel1 = SEL1_PC; sel2 = SEL2_BUS1; ld_address_reg = 1'b1;
                state_d = S_BR1;
              end else begin
                // untaken: step PC past the inline address byte
                inc_pc = 1'b1; instr_done = 1'b1;
                state_d = S_FET1;
              end
            end
            default: state_d = S_FET1;
          endcase
        end
      end
      S_EX1: begin
        sel1 = reg_sel1(dest); sel2 = SEL2_ALU;
        ld_reg_z = 1'b1; ld_r = ld_r_dest; instr_done = 1'b1;
        state_d = S_FET1;
      end
      S_RD1, S_WR1: begin
        sel2 = SEL2_MEM; ld_address_reg = 1'b1; inc_pc = 1'b1;
        state_d = (state_q == S_RD1) ? S_RD2 : S_WR2;
      end
      S_RD2: begin
        sel2 = SEL2_MEM; ld_r = ld_r_dest; instr_done = 1'b1;
        state_d = S_FET1;
      end
      S_WR2: begin
        sel1 = reg_sel1(src); mem_write = 1'b1; instr_done = 1'b1;
        state_d = S_FET1;
      end
      S_BR1: begin
        sel2 = SEL2_MEM; ld_address_reg = 1'b1;
        state_d = S_BR2;
      end
      S_BR2: begin
        sel2 = SEL2_MEM; ld_pc = 1'b1; instr_done = 1'b1;
        state_d = S_FET1;
      end
      S_HALT: begin
`ifdef RISC_CU_ILLEGAL_TRAP_EN
        halted = 1'b1;
`endif
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase

    {ld_r3, ld_r2, ld_r1, ld_r0} = ld_r;
    sel_bus1_mux = sel1_size'(sel1);
    sel_bus2_mux = sel2_size'(sel2);
  end

endmodule

// File: tb/tb_risc_control_unit.sv
// Directed bench for risc_control_unit: per-instruction expected micro-step queue checked every cycle.
module tb_risc_control_unit;

  typedef struct packed {
    logic [3:0] ld_r;
    logic       ld_pc, inc_pc, ld_ir, ld_addr, ld_y, ld_z;
    logic [2:0] sel1;
    logic [1:0] sel2;
    logic       mem_write, done, halted;
  } out_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic       zero_flag = 1'b0;
  logic ld_r0, ld_r1, ld_r2, ld_r3, ld_pc, inc_pc, ld_ir, ld_address_reg, ld_reg_y, ld_reg_z;
  logic [2:0] sel_bus1_mux;
  logic [1:0] sel_bus2_mux;
  logic mem_write, instr_done, halted;

  out_t dut;
  out_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   ncyc = 0, done_ncyc = -1;

  always #5 clk = ~clk;

  risc_control_unit #(
    .DATAWIDTH(8), .opcode_size(4), .sel1_size(3), .sel2_size(2)
  ) u_dut (
    .clk(clk), .clr(clr), .instruction(instruction), .zero_flag(zero_flag),
    .ld_r0(ld_r0), .ld_r1(ld_r1), .ld_r2(ld_r2), .ld_r3(ld_r3),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .ld_ir(ld_ir), .ld_address_reg(ld_address_reg),
    .ld_reg_y(ld_reg_y), .ld_reg_z(ld_reg_z),
    .sel_bus1_mux(sel_bus1_mux), .sel_bus2_mux(sel_bus2_mux),
    .mem_write(mem_write), .instr_done(instr_done), .halted(halted)
  );

  always_comb begin
    dut = '{ld_r: {ld_r3, ld_r2, ld_r1, ld_r0}, ld_pc: ld_pc, inc_pc: inc_pc, ld_ir: ld_ir,
            ld_addr: ld_address_reg, ld_y: ld_reg_y, ld_z: ld_reg_z,
            sel1: sel_bus1_mux, sel2: sel_bus2_mux,
            mem_write: mem_write, done: instr_done, halted: halted};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs for every clock of one instruction, fetch included.
  task automatic model_instr(input logic [7:0] ins, input logic zf, output out_t seq[$]);
    logic [3:0] op;
    logic [1:0] s, d;
    out_t v;
    op = ins[7:4]; s = ins[3:2]; d = ins[1:0];
    seq = {};
    v = '0; v.sel1 = 3'd4; v.sel2 = 2'd1; v.ld_addr = 1; v.inc_pc = 1; seq.push_back(v);
    v = '0; v.sel2 = 2'd2; v.ld_ir = 1; seq.push_back(v);
    v = '0;
    if (op == 0) begin
      v.done = 1; seq.push_back(v);
    end else if (op >= 1 && op <= 3) begin
      v.sel1 = {1'b0, s}; v.sel2 = 2'd1; v.ld_y = 1; seq.push_back(v);
      v = '0; v.sel1 = {1'b0, d}; v.sel2 = 2'd0; v.ld_z = 1; v.ld_r = 4'b0001 << d; v.done = 1;
      seq.push_back(v);
    end else if (op == 4) begin
      v.sel1 = {1'b0, s}; v.sel2 = 2'd0; v.ld_z = 1; v.ld_r = 4'b0001 << d; v.done = 1;
      seq.push_back(v);
    end else if ((op >= 5 && op <= 7) || (op == 8 && zf)) begin
      v.sel1 = 3'd4; v.sel2 = 2'd1; v.ld_addr = 1; seq.push_back(v);
      v = '0; v.sel2 = 2'd2; v.ld_addr = 1; v.inc_pc = (op == 5 || op == 6); seq.push_back(v);
      v = '0; v.done = 1;
      if (op == 5) begin v.sel2 = 2'd2; v.ld_r = 4'b0001 << d; end
      else if (op == 6) begin v.sel1 = {1'b0, s}; v.mem_write = 1; end
      else begin v.sel2 = 2'd2; v.ld_pc = 1; end
      seq.push_back(v);
    end else if (op == 8) begin
      v.inc_pc = 1; v.done = 1; seq.push_back(v);
    end else begin
`ifdef RISC_CU_ILLEGAL_TRAP_EN
      seq.push_back(v);
      v.halted = 1;
      for (int i = 0; i < 10; i++) seq.push_back(v);
`else
      v.done = 1; seq.push_back(v);
`endif
    end
  endtask

  always @(negedge clk) begin
    out_t e;
    ncyc++;
    if (instr_done) done_ncyc = ncyc;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("cyc%0d_outputs", ncyc), 32'(dut), 32'(e));
      chk($sformatf("cyc%0d_pc_excl", ncyc), 32'(ld_pc & inc_pc), 32'd0);
      chk($sformatf("cyc%0d_ldr_onehot", ncyc), 32'($countones(dut.ld_r) > 1), 32'd0);
    end
  end

  // Called at posedge+1 with the DUT in FET1; cut>0 runs only that many clocks.
  task automatic run_instr(input logic [7:0] ins, input logic zf, input int lat, input int cut);
    out_t seq[$];
    int n, start;
    chk($sformatf("fet1_%h", ins), 32'(dut), 32'h0000_1488);
    instruction = ins; zero_flag = zf;
    model_instr(ins, zf, seq);
    n = (cut > 0) ? cut : seq.size();
    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
    start = ncyc;
    repeat (n) @(posedge clk);
    #1;
    if (lat > 0) chk($sformatf("latency_%h", ins), 32'(done_ncyc - start), 32'(lat));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int k);
    clr = 1'b0;
    #1;
    chk("async_clr_zero", 32'(dut), 32'd0);
    for (int i = 0; i < k; i++) exp_q.push_back('0);
    repeat (k) @(posedge clk);
    #1;
    clr = 1'b1;
    exp_q.push_back('0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(2);
    run_instr(8'h16, 1'b0, 4, 0);
    run_instr(8'h83, 1'b0, 3, 0);
    run_instr(8'h83, 1'b1, 5, 0);
    run_instr(8'h64, 1'b0, 5, 0);
    run_instr(8'h00, 1'b1, 3, 0);
    run_instr(8'h5B, 1'b0, 5, 0);
    run_instr(8'h4E, 1'b1, 3, 0);
    run_instr(8'h2D, 1'b0, 4, 0);
    run_instr(8'h3C, 1'b1, 4, 0);
    run_instr(8'h70, 1'b0, 5, 0);
`ifdef RISC_CU_ILLEGAL_TRAP_EN
    run_instr(8'hF0, 1'b0, 0, 0);
    chk("halt_held", 32'(halted), 32'd1);
    do_reset(2);
`else
    run_instr(8'hF0, 1'b0, 3, 0);
    chk("halt_tied_low", 32'(halted), 32'd0);
`endif
    run_instr(8'h5B, 1'b0, 0, 3);
    do_reset(3);
    run_instr(8'h00, 1'b0, 3, 0);
    run_instr(8'h1B, 1'b0, 4, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
